// File: rtl/mem_copy_dma.sv
// -----------------------------------------------------------------------------
// mem_copy_dma
//
// Small DMA engine that copies a block of bytes from one address range of the
// CPU data memory to another. It drives the 8-bit synchronous RAM port
// directly. Each byte takes three cycles:
//   RD  : source address on the bus.
//   CAP : read data is valid; it is latched as the write data.
//   WR  : destination address on the bus with the write strobe high.
//
// A request is rejected, with done and err pulsing together, if either range
// would run past the top of the address space. A zero-length request completes
// with a bare done pulse.
//
// Optional feature (macro MEM_COPY_MEMMOVE_EN): when the destination overlaps
// the source from above, the copy runs from the last byte down to the first.
// The result is then a non-destructive memmove. Without the macro every copy
// runs ascending, so such an overlap repeats the source pattern.
//
// Ports:
//   clk          system clock; all state changes on the rising edge
//   reset        synchronous, active-high reset
//   start        one-cycle request, only looked at while idle
//   src_addr     first source byte address
//   dst_addr     first destination byte address
//   length       number of bytes to copy
//   busy         high while a transfer is in progress
//   done         one-cycle pulse when a transfer ends (also zero-length/rejected)
//   err          one-cycle pulse together with done for a rejected request
//   mem_address  registered memory address
//   mem_write    registered memory write strobe
//   mem_wdata    registered memory write data
//   mem_rdata    memory read data (valid the cycle after the address)
// -----------------------------------------------------------------------------
module mem_copy_dma #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Sums are one bit wider than the wider operand, so they cannot overflow.
    localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
    localparam logic [SUM_W-1:0] SPACE = SUM_W'(1) << ADDR_W;

    typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] src_reg, src_next;
    logic [ADDR_W-1:0] dst_reg, dst_next;
    logic [LEN_W-1:0]  count_reg, count_next;
    logic              desc_reg, desc_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic [ADDR_W-1:0] mem_address_reg, mem_address_next;
    logic              mem_write_reg, mem_write_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;

    logic [SUM_W-1:0]  src_sum, dst_sum;
    logic              range_bad;
    logic              descend;
    logic [ADDR_W-1:0] start_src, start_dst;
    logic [ADDR_W-1:0] src_step, dst_step;

    assign src_sum   = SUM_W'(src_addr) + SUM_W'(length);
    assign dst_sum   = SUM_W'(dst_addr) + SUM_W'(length);
    // An end address exactly at 2^ADDR_W is allowed: the last byte is the top one.
    assign range_bad = (src_sum > SPACE) || (dst_sum > SPACE);

`ifdef MEM_COPY_MEMMOVE_EN
    // Destination starts inside the source block: copy top-down so no source
    // byte is overwritten before it has been read.
    assign descend = (dst_addr > src_addr) && (SUM_W'(dst_addr) < src_sum);
`else
    assign descend = 1'b0;
`endif

    // A descending copy starts at the last byte of each range. The range check
    // guarantees that these addresses do not wrap.
    assign start_src = descend ? src_addr + ADDR_W'(length) - ADDR_W'(1) : src_addr;
    assign start_dst = descend ? dst_addr + ADDR_W'(length) - ADDR_W'(1) : dst_addr;

    assign src_step = desc_reg ? src_reg - ADDR_W'(1) : src_reg + ADDR_W'(1);
    assign dst_step = desc_reg ? dst_reg - ADDR_W'(1) : dst_reg + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            src_reg         <= '0;
            dst_reg         <= '0;
            count_reg       <= '0;
            desc_reg        <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            err_reg         <= 1'b0;
            mem_address_reg <= '0;
            mem_write_reg   <= 1'b0;
            mem_wdata_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            src_reg         <= src_next;
            dst_reg         <= dst_next;
            count_reg       <= count_next;
            desc_reg        <= desc_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
            err_reg         <= err_next;
            mem_address_reg <= mem_address_next;
            mem_write_reg   <= mem_write_next;
            mem_wdata_reg   <= mem_wdata_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        src_next         = src_reg;
        dst_next         = dst_reg;
        count_next       = count_reg;
        desc_next        = desc_reg;
        busy_next        = busy_reg;
        done_next        = 1'b0;
        err_next         = 1'b0;
        mem_address_next = mem_address_reg;
        mem_write_next   = 1'b0;
        mem_wdata_next   = mem_wdata_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (range_bad) begin
                        done_next = 1'b1;
                        err_next  = 1'b1;
                    end else if (length == '0) begin
                        done_next = 1'b1;
                    end else begin
                        src_next         = start_src;
                        dst_next         = start_dst;
                        count_next       = length;
                        desc_next        = descend;
                        busy_next        = 1'b1;
                        mem_address_next = start_src;
                        state_next       = RD;
                    end
                end
            end
            RD: begin
                // The RAM registers the read address at this edge.
                state_next = CAP;
            end
            CAP: begin
                mem_wdata_next   = mem_rdata;
                mem_address_next = dst_reg;
                mem_write_next   = 1'b1;
                state_next       = WR;
            end
            WR: begin
                // The RAM performs the write at this edge.
                count_next = count_reg - LEN_W'(1);
                src_next   = src_step;
                dst_next   = dst_step;
                if (count_reg == LEN_W'(1)) begin
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    mem_address_next = src_step;
                    state_next       = RD;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign err         = err_reg;
    assign mem_address = mem_address_reg;
    assign mem_write   = mem_write_reg;
    assign mem_wdata   = mem_wdata_reg;

endmodule

// File: tb/tb_mem_copy_dma.sv
// -----------------------------------------------------------------------------
// Testbench for mem_copy_dma. The bench contains a 256-byte synchronous RAM that
// the DUT drives. A reference byte array is updated with plain memcpy/memmove
// semantics after each request. Each request is then checked for done timing,
// busy/write cycle counts, write phase and the final memory contents.
// -----------------------------------------------------------------------------
module tb_mem_copy_dma;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] src_addr, dst_addr, length;
    logic       busy, done, err;
    logic [7:0] mem_address;
    logic       mem_write;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    // Bench-side RAM, with a preload port so that only one process writes it.
    logic [7:0] ram [256];
    logic       pl_en;
    logic [7:0] pl_addr, pl_data;

    logic [7:0] ref_mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_copy_dma #(.ADDR_W(8), .DATA_W(8), .LEN_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_address(mem_address),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always @(posedge clk) begin
        if (pl_en)
            ram[pl_addr] <= pl_data;
        else if (mem_write)
            ram[mem_address] <= mem_wdata;
        else
            mem_rdata <= ram[mem_address];
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic preload(input int a, input int d);
        pl_addr = 8'(a);
        pl_data = 8'(d);
        pl_en   = 1'b1;
        @(posedge clk); #1;
        pl_en   = 1'b0;
        ref_mem[a] = 8'(d);
    endtask

    task automatic check_mem(input string tag);
        int m = 0;
        for (int i = 0; i < 256; i++)
            if (ram[i] !== ref_mem[i]) m++;
        check(tag, m, 0);
    endtask

    // Issues one request and observes it until a few cycles past the expected
    // done. restart_cyc > 0 pulses start again in that cycle.
    task automatic run_copy(input int s, input int d, input int l, input int restart_cyc);
        int exp_done, done_cyc, done_cnt, err_cnt, busy_cnt, wr_cnt, bad_wr, clash;
        bit rej, acc;
        logic [7:0] snap [256];
        rej = (s + l > 256) || (d + l > 256);
        acc = !rej && (l != 0);
        exp_done = acc ? 3 * l + 1 : 1;
        done_cyc = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0;
        wr_cnt = 0; bad_wr = 0; clash = 0;

        src_addr = 8'(s); dst_addr = 8'(d); length = 8'(l); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= exp_done + 4; cyc++) begin
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (err) err_cnt++;
            if (busy) busy_cnt++;
            if (busy && done) clash++;
            if (mem_write) begin
                wr_cnt++;
                if (cyc % 3 != 0) bad_wr++;
            end
            if (cyc == restart_cyc) begin
                src_addr = 8'($urandom_range(0, 100));
                dst_addr = 8'($urandom_range(0, 100));
                length   = 8'd5;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;

        // Reference: byte copy from the source range into the destination range.
        if (acc) begin
`ifdef MEM_COPY_MEMMOVE_EN
            for (int i = 0; i < l; i++) snap[i] = ref_mem[s + i];
            for (int i = 0; i < l; i++) ref_mem[d + i] = snap[i];
`else
            for (int i = 0; i < l; i++) ref_mem[d + i] = ref_mem[s + i];
`endif
        end

        $display("[TB] copy src=%02h dst=%02h len=%0d done_cycle=%0d err_pulses=%0d writes=%0d",
                 s, d, l, done_cyc, err_cnt, wr_cnt);
        check("done_cycle", done_cyc, exp_done);
        check("done_count", done_cnt, 1);
        check("err_count", err_cnt, rej ? 1 : 0);
        check("busy_cycles", busy_cnt, acc ? 3 * l : 0);
        check("write_cycles", wr_cnt, acc ? l : 0);
        check("write_phase", bad_wr, 0);
        check("busy_done_clash", clash, 0);
        check_mem("mem_contents");
    endtask

    initial begin
        int dn, wr;
        reset = 1'b1; start = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        src_addr = '0; dst_addr = '0; length = '0;

        // Random initial memory image (the DUT is held in reset meanwhile).
        for (int i = 0; i < 256; i++) preload(i, $urandom_range(0, 255));

        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_mem_write", int'(mem_write), 0);
        check("rst_mem_address", int'(mem_address), 0);
        check("rst_mem_wdata", int'(mem_wdata), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Reset in cycle 5 of a 4-byte copy: only byte 0 reaches the destination.
        src_addr = 8'h80; dst_addr = 8'hA0; length = 8'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_mem_write", int'(mem_write), 0);
        check("abort_mem_address", int'(mem_address), 0);
        check("abort_mem_wdata", int'(mem_wdata), 0);
        dn = 0; wr = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) dn++;
            if (mem_write) wr++;
            @(posedge clk); #1;
        end
        check("abort_no_done", dn, 0);
        check("abort_no_write", wr, 0);
        ref_mem[8'hA0] = ref_mem[8'h80];
        $display("[TB] reset abort src=80 dst=a0 len=4 done_pulses=%0d writes_after=%0d", dn, wr);
        check_mem("abort_mem");

        // Basic copy.
        preload(8'h80, 8'h11); preload(8'h81, 8'h22);
        preload(8'h82, 8'h33); preload(8'h83, 8'h44);
        run_copy(8'h80, 8'hC0, 4, 0);
        check("basic_c3", int'(ram[8'hC3]), 8'h44);

        // Zero length, range rejection, boundary acceptance.
        run_copy(8'h10, 8'h20, 0, 0);
        run_copy(8'hFE, 8'h80, 3, 0);
        run_copy(8'h40, 8'hFE, 3, 0);
        run_copy(8'hFD, 8'h40, 3, 0);
        run_copy(8'h30, 8'hFD, 3, 0);

        // A second start while busy is ignored.
        run_copy(8'h50, 8'h60, 2, 4);

        // Overlap with the destination above the source.
        preload(8'h80, 1); preload(8'h81, 2); preload(8'h82, 3); preload(8'h83, 4);
        run_copy(8'h80, 8'h81, 3, 0);
`ifdef MEM_COPY_MEMMOVE_EN
        check("overlap_83", int'(ram[8'h83]), 3);
`else
        check("overlap_83", int'(ram[8'h83]), 1);
`endif
        // Overlap with the destination below the source.
        run_copy(8'h84, 8'h82, 5, 0);

        // Random requests; some of them fall outside the address space.
        for (int t = 0; t < 24; t++) begin
            int s, d, l;
            s = $urandom_range(0, 255);
            d = (t % 4 == 0) ? s + $urandom_range(0, 6) : $urandom_range(0, 255);
            if (d > 255) d = 255;
            l = $urandom_range(0, 10);
            run_copy(s, d, l, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
